muldiv_seq: RTL

MULDIV_SEQ -- requirements
Module: muldiv_seq

---
 rtl/muldiv_pkg.sv | 24 ++
 rtl/div_step.sv | 24 ++
 rtl/muldiv_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared width, state encoding and RV32M funct3 codes for muldiv_seq
package muldiv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DPREP,
        ST_DITER,
        ST_DFIX,
        ST_DONE
    } state_t;

    localparam logic [2:0] F_MUL    = 3'b000;
    localparam logic [2:0] F_MULH   = 3'b001;
    localparam logic [2:0] F_MULHSU = 3'b010;
    localparam logic [2:0] F_MULHU  = 3'b011;
    localparam logic [2:0] F_DIV    = 3'b100;
    localparam logic [2:0] F_DIVU   = 3'b101;
    localparam logic [2:0] F_REM    = 3'b110;
    localparam logic [2:0] F_REMU   = 3'b111;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring radix-2 division step (combinational)
module div_step
    import muldiv_pkg::*;
(
    input  logic [XLEN-1:0] rem,
    input  logic            bit_in,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_next,
    output logic            q_bit
);

    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    // Remainder stays below the divisor, so the shifted value fits in XLEN+1 bits.
    assign shifted = {rem, bit_in};
    assign diff    = shifted - {1'b0, divisor};

    always_comb begin
        q_bit    = ~diff[XLEN];
        rem_next = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - sequential RV32M multiply/divide unit (1-cycle multiply, 32-step divide)
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      func,
    input  logic [XLEN-1:0] din1,
    input  logic [XLEN-1:0] din2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] dout
);
    import muldiv_pkg::*;

    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    state_t          state;
    state_t          state_next;
    logic [2:0]      func_q;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] rem;
    logic [4:0]      cnt;
    logic            neg_q;
    logic            neg_r;

    logic s1, s2, mul_hi, div_signed, want_rem;

    always_comb begin
        s1         = 1'b1;
        s2         = 1'b1;
        mul_hi     = 1'b1;
        div_signed = 1'b0;
        want_rem   = 1'b0;
        case (func_q)
            F_MUL:    mul_hi = 1'b0;
            F_MULH:   ;
            F_MULHSU: s2 = 1'b0;
            F_MULHU:  begin s1 = 1'b0; s2 = 1'b0; end
            F_DIV:    div_signed = 1'b1;
            F_DIVU:   ;
            F_REM:    begin div_signed = 1'b1; want_rem = 1'b1; end
            F_REMU:   want_rem = 1'b1;
            default:  ;
        endcase
    end

    logic [XLEN:0]          mul_a;
    logic [XLEN:0]          mul_b;
    logic signed [2*XLEN-1:0] mul_a_ext;
    logic signed [2*XLEN-1:0] mul_b_ext;
    logic [2*XLEN-1:0]      prod;

    // A 33x33 signed product covers all four sign/zero-extension combinations.
    assign mul_a     = {s1 & op1[XLEN-1], op1};
    assign mul_b     = {s2 & op2[XLEN-1], op2};
    assign mul_a_ext = $signed(mul_a);
    assign mul_b_ext = $signed(mul_b);
    assign prod      = mul_a_ext * mul_b_ext;

    logic            div_zero;
    logic            div_ovf;
    logic            div_special;
    logic [XLEN-1:0] abs1;
    logic [XLEN-1:0] abs2;
    logic [XLEN-1:0] step_rem;
    logic            step_q;

    assign div_zero    = (op2 == '0);
    assign div_ovf     = div_signed && (op1 == MIN_NEG) && (op2 == '1);
    assign div_special = div_zero || div_ovf;
    assign abs1        = (div_signed && op1[XLEN-1]) ? -op1 : op1;
    assign abs2        = (div_signed && op2[XLEN-1]) ? -op2 : op2;

    // op1 doubles as the dividend/quotient shift register during DITER.
    div_step u_div_step (
        .rem      (rem),
        .bit_in   (op1[XLEN-1]),
        .divisor  (op2),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_IDLE;
            func_q <= '0;
            op1    <= '0;
            op2    <= '0;
            rem    <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dout   <= '0;
        end else begin
            state <= state_next;
            if (!flush) begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            func_q <= func;
                            op1    <= din1;
                            op2    <= din2;
                        end
                    end
                    ST_MUL: dout <= mul_hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                    ST_DPREP: begin
                        if (div_zero) begin
                            dout <= want_rem ? op1 : '1;
                        end else if (div_ovf) begin
                            dout <= want_rem ? '0 : MIN_NEG;
                        end else begin
                            op1   <= abs1;
                            op2   <= abs2;
                            rem   <= '0;
                            cnt   <= '0;
                            neg_q <= div_signed & (op1[XLEN-1] ^ op2[XLEN-1]);
                            neg_r <= div_signed & op1[XLEN-1];
                        end
                    end
                    ST_DITER: begin
                        op1 <= {op1[XLEN-2:0], step_q};
                        rem <= step_rem;
                        cnt <= cnt + 5'd1;
                    end
                    ST_DFIX: begin
                        if (want_rem) dout <= neg_r ? -rem : rem;
                        else          dout <= neg_q ? -op1 : op1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = func[2] ? ST_DPREP : ST_MUL;
            ST_MUL:   state_next = ST_DONE;
            ST_DPREP: state_next = div_special ? ST_DONE : ST_DITER;
            ST_DITER: if (cnt == 5'd31) state_next = ST_DFIX;
            ST_DFIX:  state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
        if (flush) state_next = ST_IDLE;
    end

    always_comb begin
        busy = (state != ST_IDLE);
        done = (state == ST_DONE);
    end

endmodule
